// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. One operation is
//   accepted at a time over a valid/ready handshake. Its operands are
//   registered and held on the ALU inputs. The ALU output is captured one
//   cycle later and returned on a tagged response channel that supports
//   backpressure.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   reqN_valid / reqN_ready     request handshake for requester N (N = 0, 1)
//   reqN_op1, reqN_op2          operands A and B from requester N
//   reqN_ctrl                   3-bit ALU control code from requester N
//   alu_op1, alu_op2            registered operands driven to the ALU
//   alu_control                 registered control code driven to the ALU
//   alu_result, alu_zf          ALU result and zero flag
//   rsp_valid / rsp_ready       response handshake
//   rsp_id                      requester that issued the operation
//   rsp_data, rsp_zf            captured ALU result and zero flag
//
// Parameters
//   WIDTH       operand and result width
//   FIXED_PRIO  0 = round-robin, 1 = requester 0 always wins a tie

module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       pend_id;
  logic       grant0;
  logic       grant1;

  // Tie-break: in round-robin mode the requester that did not win the last
  // accept gets the grant, so last_grant resetting to 1 favours requester 0.
  // Fixed-priority mode always hands a tie to requester 0. A lone valid is
  // granted regardless of history.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRIO || last_grant) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Ready is only offered while idle. It is also held low during reset so
  // that nobody believes an operation was taken in a cycle that gets wiped.
  assign req0_ready = (state == IDLE) && !rst && grant0;
  assign req1_ready = (state == IDLE) && !rst && grant1;

  // Main sequencer. IDLE latches the granted operation into the operand
  // registers that feed the ALU. Those registers change only on an accept,
  // so the ALU inputs never glitch. EXEC gives the ALU one full cycle to
  // settle and then captures its output. RESP holds the response until the
  // consumer takes it. No new request is accepted in that handshake cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      pend_id     <= 1'b0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_control <= 3'b000;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_zf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_op1     <= req0_op1;
            alu_op2     <= req0_op2;
            alu_control <= req0_ctrl;
            pend_id     <= 1'b0;
            last_grant  <= 1'b0;
            state       <= EXEC;
          end else if (req1_ready) begin
            alu_op1     <= req1_op1;
            alu_op2     <= req1_op2;
            alu_control <= req1_ctrl;
            pend_id     <= 1'b1;
            last_grant  <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_zf    <= alu_zf;
          rsp_id    <= pend_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. Two instances share the same
//   stimulus: a round-robin one and a fixed-priority one. Each instance has
//   its own behavioural ALU.

module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]       req0_ctrl, req1_ctrl;
  logic             rsp_ready;

  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] alu_op1, alu_op2, alu_result, rsp_data;
  logic [2:0]       alu_control;
  logic             alu_zf, rsp_valid, rsp_id, rsp_zf;

  logic             fp_req0_ready, fp_req1_ready;
  logic [WIDTH-1:0] fp_alu_op1, fp_alu_op2, fp_alu_result, fp_rsp_data;
  logic [2:0]       fp_alu_control;
  logic             fp_alu_zf, fp_rsp_valid, fp_rsp_id, fp_rsp_zf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       ctrl;
    logic             id;
    logic [WIDTH-1:0] exp_data;
    logic             exp_zf;
    logic             zf_valid;
  } vec_t;

  vec_t vecs [10];

  // Behavioural ALU: arithmetic straight from the operation definitions.
  // Undefined codes return zero.
  function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0] c);
    case (c)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b011:  return ~(a | b);
      3'b111:  return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign alu_result    = alu_model(alu_op1, alu_op2, alu_control);
  assign alu_zf        = (alu_result == '0);
  assign fp_alu_result = alu_model(fp_alu_op1, fp_alu_op2, fp_alu_control);
  assign fp_alu_zf     = (fp_alu_result == '0);

  // Round-robin instance under test.
  alu_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zf(rsp_zf)
  );

  // Fixed-priority instance, fed the same requests.
  alu_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .alu_op1(fp_alu_op1), .alu_op2(fp_alu_op2), .alu_control(fp_alu_control),
    .alu_result(fp_alu_result), .alu_zf(fp_alu_zf),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_data(fp_rsp_data), .rsp_zf(fp_rsp_zf)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a report
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req0_ctrl = 3'b000;
    req1_op1 = '0; req1_op2 = '0; req1_ctrl = 3'b000;
    rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated operation with the consumer always ready. The request is
  // issued in an idle cycle. It is checked through accept, execute,
  // response and return to idle.
  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_op1 = v.op1; req0_op2 = v.op2; req0_ctrl = v.ctrl;
    end else begin
      req1_valid = 1'b1; req1_op1 = v.op1; req1_op2 = v.op2; req1_ctrl = v.ctrl;
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput($sformatf("vec%0d_ready0", idx), 32'(req0_ready), 32'(v.id == 1'b0));
    checkOutput($sformatf("vec%0d_ready1", idx), 32'(req1_ready), 32'(v.id == 1'b1));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checkOutput($sformatf("vec%0d_alu_control", idx), 32'(alu_control), 32'(v.ctrl));
    checkOutput($sformatf("vec%0d_alu_op1", idx), alu_op1, v.op1);
    checkOutput($sformatf("vec%0d_exec_valid", idx), 32'(rsp_valid), 32'd0);
    tick();
    #1;
    checkOutput($sformatf("vec%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
    checkOutput($sformatf("vec%0d_rsp_data", idx), rsp_data, v.exp_data);
    checkOutput($sformatf("vec%0d_rsp_id", idx), 32'(rsp_id), 32'(v.id));
    if (v.zf_valid) checkOutput($sformatf("vec%0d_rsp_zf", idx), 32'(rsp_zf), 32'(v.exp_zf));
    tick();
    #1;
    checkOutput($sformatf("vec%0d_rsp_done", idx), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int rr_acc_id[$];
    int rr_acc_cyc[$];
    int rr_rsp_id[$];
    logic [WIDTH-1:0] rr_rsp_data[$];
    int fp_acc_id[$];
    int fp_acc_cyc[$];
    logic [WIDTH-1:0] held_data;
    logic [2:0] codes [7];
    logic m_last, m_busy, exp_id, exp_zf, winner;
    int m_accept;
    logic [WIDTH-1:0] exp_data;
    logic [2:0] exp_ctrl;

    vecs[0] = '{32'd5, 32'd3, 3'b010, 1'b0, 32'd8, 1'b0, 1'b1};
    vecs[1] = '{32'd7, 32'd7, 3'b110, 1'b1, 32'd0, 1'b1, 1'b1};
    vecs[2] = '{32'd3, 32'd9, 3'b111, 1'b1, 32'd1, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_00F0, 32'h0000_003C, 3'b000, 1'b0, 32'h0000_0030, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_00F0, 32'h0000_000F, 3'b001, 1'b1, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[5] = '{32'd0, 32'd0, 3'b011, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'd1, 3'b010, 1'b1, 32'd0, 1'b1, 1'b1};
    vecs[7] = '{32'd0, 32'd1, 3'b110, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[8] = '{32'd9, 32'd3, 3'b111, 1'b0, 32'd0, 1'b0, 1'b0};
    vecs[9] = '{32'd5, 32'd5, 3'b100, 1'b1, 32'd0, 1'b0, 1'b0};

    codes[0] = 3'b010; codes[1] = 3'b110; codes[2] = 3'b000; codes[3] = 3'b001;
    codes[4] = 3'b011; codes[5] = 3'b111; codes[6] = 3'b100;

    // Reset values, with a request pending so gated ready is visible
    quiet_inputs();
    req0_valid = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_ready0", 32'(req0_ready), 32'd0);
    checkOutput("reset_ready1", 32'(req1_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_rsp_zf", 32'(rsp_zf), 32'd0);
    checkOutput("reset_alu_op1", alu_op1, 32'd0);
    checkOutput("reset_alu_op2", alu_op2, 32'd0);
    checkOutput("reset_alu_control", 32'(alu_control), 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;

    // Table-driven single operations
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Both requesters valid continuously from reset
    quiet_inputs();
    do_reset();
    req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd1; req0_ctrl = 3'b010;
    req1_valid = 1'b1; req1_op1 = 32'd20; req1_op2 = 32'd1; req1_ctrl = 3'b010;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        checkOutput("rr_one_ready", 32'(req0_ready & req1_ready), 32'd0);
        rr_acc_id.push_back(req1_ready ? 1 : 0);
        rr_acc_cyc.push_back(c);
      end
      if (rsp_valid && rsp_ready) begin
        rr_rsp_id.push_back(int'(rsp_id));
        rr_rsp_data.push_back(rsp_data);
      end
      checkOutput("fp_req1_never", 32'(fp_req1_ready), 32'd0);
      if (fp_req0_ready) begin
        fp_acc_id.push_back(0);
        fp_acc_cyc.push_back(c);
      end
      if (fp_rsp_valid && rsp_ready) begin
        checkOutput("fp_rsp_id", 32'(fp_rsp_id), 32'd0);
        checkOutput("fp_rsp_data", fp_rsp_data, 32'd11);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("rr_accept_count", 32'(rr_acc_id.size()), 32'd4);
    checkOutput("rr_rsp_count", 32'(rr_rsp_id.size()), 32'd4);
    checkOutput("fp_accept_count", 32'(fp_acc_id.size()), 32'd4);
    for (int k = 0; k < rr_acc_id.size() && k < 4; k++) begin
      checkOutput($sformatf("rr_accept_id%0d", k), 32'(rr_acc_id[k]), 32'(k % 2));
      checkOutput($sformatf("rr_accept_cyc%0d", k), 32'(rr_acc_cyc[k]), 32'(3 * k));
    end
    for (int k = 0; k < rr_rsp_id.size() && k < 4; k++) begin
      checkOutput($sformatf("rr_rsp_id%0d", k), 32'(rr_rsp_id[k]), 32'(k % 2));
      checkOutput($sformatf("rr_rsp_data%0d", k), rr_rsp_data[k], (k % 2) ? 32'd21 : 32'd11);
    end
    for (int k = 0; k < fp_acc_cyc.size() && k < 4; k++) begin
      checkOutput($sformatf("fp_accept_cyc%0d", k), 32'(fp_acc_cyc[k]), 32'(3 * k));
    end

    // Backpressure: response held while req1 waits
    quiet_inputs();
    do_reset();
    req0_valid = 1'b1; req0_op1 = 32'd4; req0_op2 = 32'd4; req0_ctrl = 3'b010;
    rsp_ready = 1'b0;
    #1;
    checkOutput("bp_accept0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b1; req1_op1 = 32'd6; req1_op2 = 32'd3; req1_ctrl = 3'b000;
    #1;
    held_data = rsp_data;
    checkOutput("bp_first_data", held_data, 32'd8);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_hold_data", rsp_data, held_data);
      checkOutput("bp_hold_id", 32'(rsp_id), 32'd0);
      checkOutput("bp_req1_blocked", 32'(req1_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_handshake_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_handshake_no_accept", 32'(req1_ready), 32'd0);
    tick();
    #1;
    checkOutput("bp_req1_accept", 32'(req1_ready), 32'd1);
    checkOutput("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
    tick();
    req1_valid = 1'b0;
    tick();
    #1;
    checkOutput("bp_second_data", rsp_data, 32'd2);
    checkOutput("bp_second_id", 32'(rsp_id), 32'd1);
    tick();

    // Reset while executing
    quiet_inputs();
    do_reset();
    req0_valid = 1'b1; req0_op1 = 32'd9; req0_op2 = 32'd2; req0_ctrl = 3'b110;
    #1;
    checkOutput("rx_accept", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rx_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rx_exec_alu_control", 32'(alu_control), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("rx_exec_no_stale", 32'(rsp_valid), 32'd0);
    end

    // Reset while a response is pending
    req0_valid = 1'b1;
    rsp_ready = 1'b0;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    checkOutput("rx_resp_pending", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checkOutput("rx_resp_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rx_resp_alu_control", 32'(alu_control), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rx_resp_no_stale", 32'(rsp_valid), 32'd0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checkOutput("rx_first_grant0", 32'(req0_ready), 32'd1);
    checkOutput("rx_first_grant1", 32'(req1_ready), 32'd0);
    tick();
    quiet_inputs();
    tick();
    tick();
    tick();

    // Randomised traffic against a transaction-level model: an accepted
    // operation answers two cycles later and occupies the arbiter until its
    // response is consumed. Ties go to whoever did not win last.
    do_reset();
    m_last = 1'b1; m_busy = 1'b0; m_accept = 0;
    exp_id = 1'b0; exp_zf = 1'b0; exp_data = '0; exp_ctrl = 3'b000;
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op1 = $urandom; req0_op2 = ($urandom_range(0, 3) == 0) ? req0_op1 : $urandom;
      req1_op1 = $urandom; req1_op2 = ($urandom_range(0, 3) == 0) ? req1_op1 : $urandom;
      req0_ctrl = codes[$urandom_range(0, 6)];
      req1_ctrl = codes[$urandom_range(0, 6)];
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!m_busy) begin
        winner = (req0_valid && req1_valid) ? !m_last : !req0_valid;
        checkOutput("rand_ready0", 32'(req0_ready), 32'(req0_valid && winner == 1'b0));
        checkOutput("rand_ready1", 32'(req1_ready), 32'(req1_valid && winner == 1'b1));
        checkOutput("rand_idle_valid", 32'(rsp_valid), 32'd0);
        if (req0_valid || req1_valid) begin
          m_busy = 1'b1;
          m_accept = i;
          m_last = winner;
          exp_id = winner;
          exp_ctrl = winner ? req1_ctrl : req0_ctrl;
          exp_data = winner ? alu_model(req1_op1, req1_op2, req1_ctrl)
                            : alu_model(req0_op1, req0_op2, req0_ctrl);
          exp_zf = (exp_data == '0);
        end
      end else begin
        checkOutput("rand_busy_ready", 32'({req0_ready, req1_ready}), 32'd0);
        checkOutput("rand_rsp_valid", 32'(rsp_valid), 32'(i >= m_accept + 2));
        if (i >= m_accept + 2) begin
          checkOutput("rand_rsp_data", rsp_data, exp_data);
          checkOutput("rand_rsp_id", 32'(rsp_id), 32'(exp_id));
          if (exp_ctrl == 3'b010 || exp_ctrl == 3'b110)
            checkOutput("rand_rsp_zf", 32'(rsp_zf), 32'(exp_zf));
          if (rsp_ready) m_busy = 1'b0;
        end
      end
      tick();
    end
    quiet_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (add/sub/and/or/nor/slt, zero flag) between two requesters, e.g. the PC-increment path and the execute path of the multi-cycle micro-controlled CPU.
- Accepts one operation at a time with a valid/ready handshake and drives the ALU from registered operands.
- Returns a tagged, registered result on a shared response channel that supports backpressure.

Parameters:
- WIDTH, 32, operand and result width. Must match the ALU.
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin, 1 = requester 0 always wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op1  in  WIDTH  requester 0 operand A.
- req0_op2  in  WIDTH  requester 0 operand B.
- req0_ctrl  in  3  requester 0 ALU control code.
- req1_valid, req1_ready, req1_op1, req1_op2, req1_ctrl: same as requester 0, for requester 1.
- alu_op1  out  WIDTH  to ALU operand A.
- alu_op2  out  WIDTH  to ALU operand B.
- alu_control  out  3  to ALU control.
- alu_result  in  WIDTH  from ALU result.
- alu_zf  in  1  from ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_data  out  WIDTH  ALU result.
- rsp_zf  out  1  ALU zero flag.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high on rst, and wins over all other activity.
- Reset values:
  - state = IDLE.
  - last_grant = 1, so requester 0 wins first.
  - alu_op1 = 0, alu_op2 = 0, alu_control = 3'b000.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_zf = 0.
  - req0_ready = 0, req1_ready = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational from the valids.
  - Only one valid: that requester is granted.
  - Both valid, FIXED_PRIO=1: requester 0 is granted.
  - Both valid, FIXED_PRIO=0: the requester not equal to last_grant is granted.
  - reqN_ready = (state==IDLE) and granted N. At most one ready is high per cycle. Ready is low in every other state.
  - Valid must not depend on ready.
  - On accept: latch opN/ctrlN into the operand registers that drive alu_op1/alu_op2/alu_control; latch id; update last_grant; go to EXEC.
  - No valid: stay in IDLE; registers hold.
- EXEC:
  - The ALU settles from the registered operands.
  - At the clock edge, capture alu_result into rsp_data, alu_zf into rsp_zf, and the latched id into rsp_id. Set rsp_valid=1 and go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_zf stay stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid goes to 0 next cycle and the FSM returns to IDLE.
  - No request is accepted in the handshake cycle.
- Latency and throughput:
  - Accept at cycle T gives rsp_valid high from T+2. With rsp_ready held high, the response handshake happens in T+2 and the next accept is earliest at T+3.
  - Throughput is one operation per 3 cycles.
- alu_* outputs hold their last latched values outside EXEC; there are no glitches to the ALU.
- ctrl codes pass through unchecked: 010 add, 110 sub, 000 and, 001 or, 011 nor, 111 unsigned slt.
  - Undefined codes make the ALU return 0. The arbiter forwards that result without flagging it.
  - rsp_zf is the ALU zero flag, derived from the add/sub result, and is meaningful only for 010/110.
  - Width: add/sub wrap modulo 2^WIDTH. Carry is not exported.
- A requester may drop valid before it is granted. Fairness is evaluated only on accept.
- Reset in EXEC or RESP discards the pending operation/response. rsp_valid is 0 the next cycle and no response is emitted.

Test Plan:
- Reset, then req0 with op1=5, op2=3, ctrl=010 and rsp_ready=1 → req0_ready=1 in the same cycle; rsp_valid=1 two cycles later with rsp_data=8, rsp_id=0, rsp_zf=0.
- req1 with op1=7, op2=7, ctrl=110 → rsp_data=0, rsp_zf=1, rsp_id=1. Then req1 with op1=3, op2=9, ctrl=111 → rsp_data=1.
- FIXED_PRIO=0, both valid continuously from reset, each doing add (op1=N, op2=1) → responses alternate with rsp_id 0,1,0,1. Each accept cycle has exactly one ready. Accepts are 3 cycles apart.
- FIXED_PRIO=1, both valid continuously → rsp_id is always 0 and req1 is never accepted while req0 is valid.
- Backpressure: rsp_ready=0 for 5 cycles with req1 valid → rsp_* held stable and req1_ready=0 throughout. When rsp_ready rises, the handshake occurs and req1 is accepted exactly 1 cycle later.
- Assert rst during EXEC, then during RESP → the next cycle shows rsp_valid=0, alu_control=000, state IDLE, and no stale response afterwards. The first later simultaneous request grants req0.
